// File: rtl/sdram_cmd_arbiter_if.sv
// Handshake and pin bundle between the SDRAM arbiter and its sub-controllers.
// The slave side is the arbiter; the master side drives requests and commands.
interface sdram_cmd_arbiter_if;
    logic        init_done;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        ref_end;
    logic [3:0]  ref_cmd;
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank;
    logic [11:0] wr_addr;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank;
    logic [11:0] rd_addr;
    logic        ref_en;
    logic        wr_en;
    logic        rd_en;
    logic        ref_pend;
    logic        ref_overrun;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;

    modport slave (
        input  init_done, init_cmd, init_addr,
        input  ref_end, ref_cmd,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output ref_en, wr_en, rd_en, ref_pend, ref_overrun,
        output sdram_cmd, sdram_bank, sdram_addr
    );

    modport master (
        output init_done, init_cmd, init_addr,
        output ref_end, ref_cmd,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  ref_en, wr_en, rd_en, ref_pend, ref_overrun,
        input  sdram_cmd, sdram_bank, sdram_addr
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM port scheduler: init, then refresh > write > read arbitration.
// Owns the refresh interval timer and drives the shared SDRAM pins.
module sdram_cmd_arbiter #(
    parameter int REF_CYCLES = 780,
    parameter int REF_CNT_W  = 10
) (
    input logic clk,
    input logic rst_n,
    sdram_cmd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        INIT, ARBIT, AREF, WRITE, READ
    } state_t;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [REF_CNT_W-1:0] CNT_LAST =
        REF_CNT_W'(REF_CYCLES - 1);

    state_t               state_q;
    logic [REF_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 ovr_q, ovr_d;
    logic                 expire;
    logic                 enter_aref;

    // Every grant returns to ARBIT, giving one idle cycle between grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            unique case (state_q)
                INIT:  if (bus.init_done) state_q <= ARBIT;
                ARBIT: begin
                    if (pend_q)          state_q <= AREF;
                    else if (bus.wr_req) state_q <= WRITE;
                    else if (bus.rd_req) state_q <= READ;
                end
                AREF:  if (bus.ref_end) state_q <= ARBIT;
                WRITE: if (bus.wr_end)  state_q <= ARBIT;
                READ:  if (bus.rd_end)  state_q <= ARBIT;
                default: state_q <= INIT;
            endcase
        end
    end

    assign expire     = (state_q != INIT) && (cnt_q == CNT_LAST);
    assign enter_aref = (state_q == ARBIT) && pend_q;

    // Free-running refresh interval; a new expiry beats a same-cycle clear.
    always_comb begin
        cnt_d  = (state_q == INIT || expire) ? '0 : cnt_q + 1'b1;
        pend_d = expire | (pend_q & ~enter_aref);
        ovr_d  = ovr_q | (expire & pend_q);
    end

    // Timer, pending flag and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // Pin mux follows the granted owner; NOP while reset is held.
    always_comb begin
        bus.sdram_cmd  = NOP;
        bus.sdram_bank = 2'b00;
        bus.sdram_addr = 12'h000;
        if (rst_n) begin
            unique case (state_q)
                INIT: begin
                    bus.sdram_cmd  = bus.init_cmd;
                    bus.sdram_addr = bus.init_addr;
                end
                AREF: bus.sdram_cmd = bus.ref_cmd;
                WRITE: begin
                    bus.sdram_cmd  = bus.wr_cmd;
                    bus.sdram_bank = bus.wr_bank;
                    bus.sdram_addr = bus.wr_addr;
                end
                READ: begin
                    bus.sdram_cmd  = bus.rd_cmd;
                    bus.sdram_bank = bus.rd_bank;
                    bus.sdram_addr = bus.rd_addr;
                end
                default: ;
            endcase
        end
    end

    assign bus.ref_en      = (state_q == AREF);
    assign bus.wr_en       = (state_q == WRITE);
    assign bus.rd_en       = (state_q == READ);
    assign bus.ref_pend    = pend_q;
    assign bus.ref_overrun = ovr_q;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Self-checking bench for sdram_cmd_arbiter with a short refresh interval.
// A cycle-level behavioural model predicts grants, flags and pins.
module tb_sdram_cmd_arbiter;
    localparam int REF = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errs = 0;
    int checks = 0;

    sdram_cmd_arbiter_if bus();

    sdram_cmd_arbiter #(.REF_CYCLES(REF), .REF_CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [22:0] dut_vec;
    assign dut_vec = {bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_pend,
                      bus.ref_overrun, bus.sdram_cmd, bus.sdram_bank,
                      bus.sdram_addr};

    // owner: 0 init, 1 idle, 2 refresh, 3 write, 4 read
    int m_own;
    int m_t;
    bit m_pend, m_ovr;
    bit m_exp;

    // m_t = clock edges since init exit; the interval expires every REF.
    assign m_exp = (m_t >= 0) && ((m_t % REF) == REF - 1);

    function automatic int next_owner();
        case (m_own)
            0: return bus.init_done ? 1 : 0;
            1: begin
                if (m_pend) return 2;
                if (bus.wr_req) return 3;
                if (bus.rd_req) return 4;
                return 1;
            end
            2: return bus.ref_end ? 1 : 2;
            3: return bus.wr_end ? 1 : 3;
            4: return bus.rd_end ? 1 : 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own <= 0;
            m_t <= -1;
            m_pend <= 1'b0;
            m_ovr <= 1'b0;
        end else begin
            m_own <= next_owner();
            m_t <= (m_own == 0) ? (bus.init_done ? 0 : -1) : m_t + 1;
            m_pend <= m_exp | (m_pend & (m_own != 1));
            m_ovr <= m_ovr | (m_exp & m_pend);
        end
    end

    function automatic logic [22:0] exp_vec();
        logic [3:0] c;
        logic [1:0] b;
        logic [11:0] a;
        c = 4'b0111;
        b = 2'b00;
        a = 12'h000;
        if (rst_n) begin
            case (m_own)
                0: begin c = bus.init_cmd; a = bus.init_addr; end
                2: c = bus.ref_cmd;
                3: begin c = bus.wr_cmd; b = bus.wr_bank; a = bus.wr_addr; end
                4: begin c = bus.rd_cmd; b = bus.rd_bank; a = bus.rd_addr; end
                default: ;
            endcase
        end
        return {m_own == 2, m_own == 3, m_own == 4, m_pend, m_ovr, c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic service_refresh();
        int n;
        n = 0;
        while (!bus.ref_pend && n < 60) begin tick(); n++; end
        checks++;
        if (!bus.ref_pend) begin
            errs++;
            $display("FAIL svc_ref_timeout: ref_pend=%b required 1", bus.ref_pend);
        end
        tick();
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (dut_vec !== {5'b0, 4'b0111, 14'h0}) begin
            errs++;
            $display("FAIL reset_vals: got %h required %h", dut_vec, {5'b0, 4'b0111, 14'h0});
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL reset_model: got %h required %h", dut_vec, exp_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (dut_vec !== {5'b0, 4'b0010, 2'b00, 12'h037}) begin
                errs++;
                $display("FAIL init_pins c=%0d: got %h required %h", c, dut_vec, {5'b0, 4'b0010, 2'b00, 12'h037});
            end
            tick();
        end
        bus.init_done = 1'b1;
        #1;
        checks++;
        if (bus.sdram_cmd !== 4'b0010) begin
            errs++;
            $display("FAIL init_last: cmd=%b required 0010", bus.sdram_cmd);
        end
        tick();
        checks++;
        if (dut_vec !== {5'b0, 4'b0111, 14'h0}) begin
            errs++;
            $display("FAIL init_exit: got %h required %h", dut_vec, {5'b0, 4'b0111, 14'h0});
        end
    endtask

    task automatic test_refresh();
        int n;
        n = 0;
        while (!bus.ref_pend && n < 40) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errs++;
                $display("FAIL ref_wait: got %h required %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (n !== REF) begin
            errs++;
            $display("FAIL ref_first: rose after %0d cycles required %0d", n, REF);
        end
        tick();
        checks++;
        if (bus.ref_en !== 1'b1 || bus.ref_pend !== 1'b0 || bus.sdram_cmd !== bus.ref_cmd) begin
            errs++;
            $display("FAIL ref_grant: en=%b pend=%b cmd=%b required 1 0 %b", bus.ref_en, bus.ref_pend, bus.sdram_cmd, bus.ref_cmd);
        end
        tick();
        tick();
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;
        #1;
        checks++;
        if (bus.ref_en !== 1'b0 || bus.sdram_cmd !== 4'b0111) begin
            errs++;
            $display("FAIL ref_done: en=%b cmd=%b required 0 0111", bus.ref_en, bus.sdram_cmd);
        end
        n = 4;
        while (!bus.ref_pend && n < 40) begin tick(); n++; end
        checks++;
        if (n !== REF) begin
            errs++;
            $display("FAIL ref_period: period %0d required %0d", n, REF);
        end
    endtask

    task automatic test_write_read();
        service_refresh();
        bus.wr_req = 1'b1;
        bus.wr_bank = 2'b01;
        bus.wr_addr = 12'h0A5;
        bus.rd_req = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errs++;
            $display("FAIL wr_early: wr_en=%b required 0", bus.wr_en);
        end
        tick();
        checks++;
        if (dut_vec !== {5'b01000, 4'b0100, 2'b01, 12'h0A5}) begin
            errs++;
            $display("FAIL wr_grant: got %h required %h", dut_vec, {5'b01000, 4'b0100, 2'b01, 12'h0A5});
        end
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        #1;
        checks++;
        if (dut_vec !== {5'b0, 4'b0111, 14'h0}) begin
            errs++;
            $display("FAIL wr_arbit: got %h required %h", dut_vec, {5'b0, 4'b0111, 14'h0});
        end
        tick();
        checks++;
        if (bus.rd_en !== 1'b1 || bus.sdram_cmd !== bus.rd_cmd || bus.sdram_addr !== bus.rd_addr) begin
            errs++;
            $display("FAIL rd_grant: en=%b cmd=%b addr=%h required 1 %b %h", bus.rd_en, bus.sdram_cmd, bus.sdram_addr, bus.rd_cmd, bus.rd_addr);
        end
        bus.rd_req = 1'b0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
    endtask

    task automatic test_priority();
        int n;
        int code;
        int exp_seq[7] = '{0, 1, 0, 2, 0, 3, 0};
        n = 0;
        while (!bus.ref_pend && n < 40) begin tick(); n++; end
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            code = bus.ref_en ? 1 : bus.wr_en ? 2 : bus.rd_en ? 3 : 0;
            checks++;
            if (code !== exp_seq[k] || dut_vec !== exp_vec()) begin
                errs++;
                $display("FAIL prio_seq k=%0d: grant %0d vec %h required %0d vec %h", k, code, dut_vec, exp_seq[k], exp_vec());
            end
            bus.ref_end = bus.ref_en;
            bus.wr_end = bus.wr_en;
            bus.rd_end = bus.rd_en;
            if (bus.wr_en) bus.wr_req = 1'b0;
            if (bus.rd_en) bus.rd_req = 1'b0;
            tick();
            bus.ref_end = 1'b0;
            bus.wr_end = 1'b0;
            bus.rd_end = 1'b0;
        end
    endtask

    task automatic test_overrun();
        int rise_at;
        int ovr_at;
        service_refresh();
        bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        rise_at = -1;
        ovr_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rise_at < 0 && bus.ref_pend) rise_at = i;
            if (ovr_at < 0 && bus.ref_overrun) ovr_at = i;
            checks++;
            if (bus.wr_en !== 1'b1 || (rise_at >= 0 && bus.ref_pend !== 1'b1)) begin
                errs++;
                $display("FAIL ovr_hold i=%0d: wr_en=%b pend=%b required 1 1", i, bus.wr_en, bus.ref_pend);
            end
        end
        checks++;
        if (rise_at < 0 || ovr_at - rise_at !== REF) begin
            errs++;
            $display("FAIL ovr_timing: rise %0d ovr %0d required gap %0d", rise_at, ovr_at, REF);
        end
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        tick();
        checks++;
        if (bus.ref_en !== 1'b1) begin
            errs++;
            $display("FAIL ovr_aref: ref_en=%b required 1", bus.ref_en);
        end
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;
        #1;
        checks++;
        if (bus.ref_overrun !== 1'b1 || bus.ref_pend !== 1'b0) begin
            errs++;
            $display("FAIL ovr_sticky: ovr=%b pend=%b required 1 0", bus.ref_overrun, bus.ref_pend);
        end
    endtask

    task automatic test_stray_and_reset();
        service_refresh();
        bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        #1;
        checks++;
        if (bus.wr_en !== 1'b1 || bus.sdram_cmd !== bus.wr_cmd || dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL stray_end: wr_en=%b vec %h required 1 vec %h", bus.wr_en, dut_vec, exp_vec());
        end
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_en !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre_read: rd_en=%b required 1", bus.rd_en);
        end
        #2;
        rst_n = 1'b0;
        bus.init_done = 1'b0;
        #1;
        checks++;
        if (dut_vec !== {5'b0, 4'b0111, 14'h0}) begin
            errs++;
            $display("FAIL rst_mid: got %h required %h", dut_vec, {5'b0, 4'b0111, 14'h0});
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut_vec !== {5'b0, 4'b0010, 2'b00, 12'h037}) begin
            errs++;
            $display("FAIL rst_init: got %h required %h", dut_vec, {5'b0, 4'b0010, 2'b00, 12'h037});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if (c == 7) bus.init_done = 1'b1;
            bus.init_cmd = 4'($urandom);
            bus.init_addr = 12'($urandom);
            bus.ref_cmd = 4'($urandom);
            bus.wr_cmd = 4'($urandom);
            bus.wr_bank = 2'($urandom);
            bus.wr_addr = 12'($urandom);
            bus.rd_cmd = 4'($urandom);
            bus.rd_bank = 2'($urandom);
            bus.rd_addr = 12'($urandom);
            if (bus.wr_en) bus.wr_req = 1'b0;
            else if (!bus.wr_req) bus.wr_req = ($urandom % 4) == 0;
            else if (($urandom % 16) == 0) bus.wr_req = 1'b0;
            if (bus.rd_en) bus.rd_req = 1'b0;
            else if (!bus.rd_req) bus.rd_req = ($urandom % 4) == 0;
            else if (($urandom % 16) == 0) bus.rd_req = 1'b0;
            bus.ref_end = bus.ref_en ? ($urandom % 3) == 0 : ($urandom % 16) == 0;
            bus.wr_end = bus.wr_en ? ($urandom % 4) == 0 : ($urandom % 16) == 0;
            bus.rd_end = bus.rd_en ? ($urandom % 4) == 0 : ($urandom % 16) == 0;
            #1;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errs++;
                $display("FAIL rand c=%0d: got %h required %h", c, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        bus.init_done = 1'b0;
        bus.init_cmd = 4'b0010;
        bus.init_addr = 12'h037;
        bus.ref_end = 1'b0;
        bus.ref_cmd = 4'b0001;
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b0;
        bus.wr_cmd = 4'b0100;
        bus.wr_bank = 2'b00;
        bus.wr_addr = 12'h000;
        bus.rd_req = 1'b0;
        bus.rd_end = 1'b0;
        bus.rd_cmd = 4'b0101;
        bus.rd_bank = 2'b10;
        bus.rd_addr = 12'h3C1;
        test_reset();
        test_init();
        test_refresh();
        test_write_read();
        test_priority();
        test_overrun();
        test_stray_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
